// File: rtl/adder_pkg.sv
// Shared defaults, slice-width helper, configuration check and the half/full
// adder cells used by the ripple slices of pipelined_adder.
package adder_pkg;

  localparam int ADDER_WIDTH  = 32;
  localparam int ADDER_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // A legal split has at least one slice, no slice narrower than one bit and
  // no remainder bits left over for an extra partial slice.
  function automatic bit stages_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Returns {carry, sum}; two half adders plus the carry merge.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry adder slice built from the package's
// full-adder cell; one instance per pipeline stage.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] s_o,
  output logic          c_o
);

  logic [SW:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < SW; i++) begin
      {carry[i+1], s_o[i]} = full_add(a_i[i], b_i[i], carry[i]);
    end
  end

  assign c_o = carry[SW];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES ripple slices with
// skew/deskew registers. Define ADDER_OVF_EN to add the registered ovf output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Handshake: a word moves in on in_valid && in_ready and out on
  // out_valid && out_ready. The whole pipe advances as one unit whenever the
  // output slot is empty or being drained, so in_ready equals that advance.
  logic             advance;
  logic [WIDTH-1:0] b_x;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_x      = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [SW-1:0]       sl_a;
    logic [SW-1:0]       sl_b;
    logic [SW-1:0]       sl_s;
    logic                sl_ci;
    logic                sl_co;
    logic                v_d;
    logic [(k+1)*SW-1:0] s_d;
    logic                v_q;
    logic                c_q;
    logic [(k+1)*SW-1:0] s_q;

    // Stage 0 reads the accepted operands; later stages read the skew
    // registers and the carry registered out of the stage before.
    if (k == 0) begin : g_src
      assign sl_a  = a[SW-1:0];
      assign sl_b  = b_x[SW-1:0];
      assign sl_ci = sub ? 1'b1 : cin;
      assign v_d   = in_valid;
      assign s_d   = sl_s;
    end else begin : g_src
      assign sl_a  = g_stg[k-1].g_skew.a_q[SW-1:0];
      assign sl_b  = g_stg[k-1].g_skew.b_q[SW-1:0];
      assign sl_ci = g_stg[k-1].c_q;
      assign v_d   = g_stg[k-1].v_q;
      assign s_d   = {sl_s, g_stg[k-1].s_q};
    end

    adder_slice #(
      .SW(SW)
    ) u_slice (
      .a_i(sl_a),
      .b_i(sl_b),
      .c_i(sl_ci),
      .s_o(sl_s),
      .c_o(sl_co)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_d;
        c_q <= sl_co;
        s_q <= s_d;
      end
    end

    // Upper operand slices not yet added ride along; slice k+1 sits in the
    // low bits so the next stage always picks from [SW-1:0].
    if (k < STAGES - 1) begin : g_skew
      localparam int RW = WIDTH - (k + 1) * SW;
      logic [RW-1:0] a_d;
      logic [RW-1:0] b_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      if (k == 0) begin : g_rest
        assign a_d = a[WIDTH-1:SW];
        assign b_d = b_x[WIDTH-1:SW];
      end else begin : g_rest
        assign a_d = g_stg[k-1].g_skew.a_q[RW+SW-1:SW];
        assign b_d = g_stg[k-1].g_skew.b_q[RW+SW-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;

`ifdef ADDER_OVF_EN
  // The last slice already carries both sign bits, so no sign pipeline is needed.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_stg[STAGES-1].sl_a[SW-1] == g_stg[STAGES-1].sl_b[SW-1]) &&
                 (g_stg[STAGES-1].sl_s[SW-1] != g_stg[STAGES-1].sl_a[SW-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder: arithmetic reference model,
// in-order scoreboard, latency, stall-hold and asynchronous-reset checks.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected results as {ovf, cout, sum}, with their accept cycles alongside.
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  bit           lat_check = 1'b0;
  bit           in_fired  = 1'b0;
  bit           held      = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plain wide arithmetic: {cout,sum} = a + b' + carry, ovf from sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W:0]   r;
    logic [W-1:0] yp;
    logic         o;
    yp = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yp} + (W+1)'(s ? 1 : c);
    o  = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
    return {o, r};
  endfunction

  // One clock: settle, score both handshakes, then move to just after the edge.
  task automatic step();
    logic [W+1:0] e;
    int           t;
    #1;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (held) begin
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum, held_sum);
      check("stall_cout", cout, held_cout);
    end
    held      = out_valid && !out_ready;
    held_sum  = sum;
    held_cout = cout;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check("sum", sum, e[W-1:0]);
        check("cout", cout, e[W]);
`ifdef ADDER_OVF_EN
        check("ovf", ovf, e[W+1]);
`endif
        if (lat_check) check("latency", cyc - t, S);
      end
    end
    in_fired = in_valid && in_ready;
    if (in_fired) begin
      exp_q.push_back(model(a, b, cin, sub));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    held = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    int n;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_fired && n < 50);
    if (!in_fired) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_ops();
    a   = $urandom();
    b   = $urandom();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n_acc;
    do_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    #0;

    // Directed corner cases with exact latency checking.
    lat_check = 1'b1;
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drain();
    send(32'd5, 32'd7, 1'b0, 1'b1);
    drain();
    send(32'd7, 32'd5, 1'b0, 1'b1);
    drain();
    send(32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    drain();

    // 16 back-to-back random operations; latency S each means consecutive outputs.
    out_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
      if (in_fired) n_acc++;
    end
    check("b2b_accepts", n_acc, 16);
    drain();

    // Fill the pipe with the output blocked, then stall for 5 cycles.
    lat_check = 1'b0;
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10 && in_ready; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
      if (in_fired) n_acc++;
    end
    check("fill_count", n_acc, S);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    drain();

    // Reset with operations in flight and a result waiting at the output.
    out_ready = 1'b1;
    for (int i = 0; i < S; i++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    exp_q.delete();
    acc_q.delete();
    held = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2 * S + 2; i++) begin
      step();
      check("no_stale", out_valid, 0);
    end

    // Random traffic with random back-pressure and bubbles.
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drain();

`ifdef ADDER_OVF_EN
    lat_check = 1'b1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain();
`endif

    check("end_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
